// File: rtl/mode_counter.sv
// ---------------------------------------------------------------------------
// mode_counter
//
// Parametrised up/down counter with a programmable modulus, run-time
// direction, synchronous clear and load, count enable, wrap or saturate
// behaviour at the range ends, and boundary event flags.
//
// Count range is 0..TOP, where TOP = MODULUS-1, or 2^WIDTH-1 when
// MODULUS = 0.
//
// Parameters:
//   WIDTH     counter width in bits (>= 2)
//   MODULUS   0 for the full range, otherwise 2 <= MODULUS <= 2^WIDTH
//
// Ports:
//   clk       clock, all state changes on the rising edge
//   rst_n     asynchronous active-low reset
//   en        count enable
//   dir       direction: 1 = up, 0 = down
//   sat       0 = wrap at the range ends, 1 = hold at the range ends
//   clr       synchronous clear (highest priority)
//   load      synchronous load (clipped to TOP)
//   load_val  value for load
//   cnt       current count
//   zero      cnt == 0
//   top       cnt == TOP
//   evt       one-cycle pulse in the cycle after a boundary edge
//   ovf       sticky boundary flag, cleared by clr or reset
// ---------------------------------------------------------------------------
module mode_counter #(
    parameter int unsigned     WIDTH   = 32,
    parameter longint unsigned MODULUS = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             dir,
    input  logic             sat,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] cnt,
    output logic             zero,
    output logic             top,
    output logic             evt,
    output logic             ovf
);

    // TOP is computed at elaboration time so that MODULUS = 2^WIDTH lands
    // on all-ones without the counter ever relying on natural overflow.
    localparam logic [WIDTH-1:0] TOP  = (MODULUS == 0) ? '1 : WIDTH'(MODULUS - 64'd1);
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    logic [WIDTH-1:0] r_cnt;
    logic             r_evt;
    logic             r_ovf;

    logic             w_at_top;
    logic             w_at_zero;

    assign w_at_top  = (r_cnt == TOP);
    assign w_at_zero = (r_cnt == '0);

    // NOTE: all state below is written with non-blocking assignments so every
    // register samples the pre-edge values of the others in the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_evt <= 1'b0;
            r_ovf <= 1'b0;
        end else if (clr) begin
            r_cnt <= '0;
            r_evt <= 1'b0;
            r_ovf <= 1'b0;
        end else if (load) begin
            r_cnt <= (load_val > TOP) ? TOP : load_val;
            r_evt <= 1'b0;
        end else if (en) begin
            if (dir) begin
                if (w_at_top) begin
                    r_cnt <= sat ? TOP : '0;
                    r_evt <= 1'b1;
                    r_ovf <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + ONE;
                    r_evt <= 1'b0;
                end
            end else begin
                if (w_at_zero) begin
                    r_cnt <= sat ? '0 : TOP;
                    r_evt <= 1'b1;
                    r_ovf <= 1'b1;
                end else begin
                    r_cnt <= r_cnt - ONE;
                    r_evt <= 1'b0;
                end
            end
        end else begin
            r_evt <= 1'b0;
        end
    end

    assign cnt  = r_cnt;
    assign zero = w_at_zero;
    assign top  = w_at_top;
    assign evt  = r_evt;
    assign ovf  = r_ovf;

endmodule
